// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for nibble_serial_subtractor.
// The ovf signal exists only when SUB_SIGNED_OVF_EN is defined.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             carry_out;
  logic             busy;
`ifdef SUB_SIGNED_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, carry_out, busy, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, carry_out, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, carry_out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, carry_out, busy
  );
`endif
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Sequential unsigned subtractor: one SLICE-bit a + ~b + carry slice reused over WIDTH/SLICE cycles.
// Optional signed-overflow flag enabled by SUB_SIGNED_OVF_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands; last result held
// RUN   | one slice per cycle, least significant first
// DONE  | result valid, held until out_ready
module nibble_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  nibble_serial_subtractor_if.slave bus
);
  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  generate
    if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_params
      $error("WIDTH must be a positive integer multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic             carry_out_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;
`ifdef SUB_SIGNED_OVF_EN
  logic             ovf_reg;
`endif

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_sum;

  // Constant-index mux keeps slice selection free of variable part-selects.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDXW'(i)) begin
        a_slice = a_reg[i*SLICE +: SLICE];
        b_slice = b_reg[i*SLICE +: SLICE];
      end
    end
    slice_sum = {1'b0, a_slice} + {1'b0, ~b_slice} + {{SLICE{1'b0}}, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      diff_reg      <= '0;
      idx           <= '0;
      carry         <= 1'b0;
      carry_out_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg        <= bus.a;
            b_reg        <= bus.b;
            carry        <= 1'b1;
            idx          <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (idx == IDXW'(i)) begin
              diff_reg[i*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
            end
          end
          carry <= slice_sum[SLICE];
          if (idx == LAST_IDX) begin
            carry_out_reg <= slice_sum[SLICE];
`ifdef SUB_SIGNED_OVF_EN
            // Top bit of the final slice is the result MSB.
            ovf_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                       (slice_sum[SLICE-1] != a_reg[WIDTH-1]);
`endif
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.diff      = diff_reg;
  assign bus.carry_out = carry_out_reg;
  assign bus.busy      = busy_reg;
`ifdef SUB_SIGNED_OVF_EN
  assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: vector table, scoreboard queue, corner sequences.
module tb_nibble_serial_subtractor;
  localparam int WIDTH = 8;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       carry;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  vec_t vecs[9];

  nibble_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_subtractor #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    e.diff  = av - bv;
    e.carry = (av >= bv);
    e.ovf   = (av[7] != bv[7]) && (e.diff[7] != av[7]);
    return e;
  endfunction

  task automatic check_result(input string name, input exp_t e);
    check({name, "_diff"}, {24'd0, bus.diff}, {24'd0, e.diff});
    check({name, "_carry"}, {31'd0, bus.carry_out}, {31'd0, e.carry});
`ifdef SUB_SIGNED_OVF_EN
    check({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
  endtask

  // Leaves the bench at posedge+1 of the accepting edge.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input exp_t e);
    int k;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_before_op", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    sb.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
  endtask

  task automatic wait_valid(input string name);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, N);
  endtask

  task automatic consume(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (bus.out_valid) check_result(name, e);
      else check({name, "_out_valid"}, 32'd0, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_out_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    check({name, "_in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    exp_t e;
    logic [7:0] ra, rb;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{a: 8'd100,  b: 8'd37,   diff: 8'h3F, carry: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: 8'd5,    b: 8'd10,   diff: 8'hFB, carry: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 8'h80,   b: 8'h01,   diff: 8'h7F, carry: 1'b1, ovf: 1'b1};
    vecs[3] = '{a: 8'hFF,   b: 8'hFF,   diff: 8'h00, carry: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: 8'h00,   b: 8'h00,   diff: 8'h00, carry: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 8'h7F,   b: 8'h80,   diff: 8'hFF, carry: 1'b0, ovf: 1'b1};
    vecs[6] = '{a: 8'h10,   b: 8'h01,   diff: 8'h0F, carry: 1'b1, ovf: 1'b0};
    vecs[7] = '{a: 8'h00,   b: 8'h01,   diff: 8'hFF, carry: 1'b0, ovf: 1'b0};
    vecs[8] = '{a: 8'hA5,   b: 8'h5A,   diff: 8'h4B, carry: 1'b1, ovf: 1'b1};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a        = '0;
    bus.b        = '0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_diff", {24'd0, bus.diff}, 32'd0);
    check("rst_carry", {31'd0, bus.carry_out}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef SUB_SIGNED_OVF_EN
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif

    for (int i = 0; i < 9; i++) begin
      e.diff  = vecs[i].diff;
      e.carry = vecs[i].carry;
      e.ovf   = vecs[i].ovf;
      start_op(vecs[i].a, vecs[i].b, e);
      check("run_busy", {31'd0, bus.busy}, 32'd1);
      check("run_in_ready", {31'd0, bus.in_ready}, 32'd0);
      wait_valid("vec");
      consume("vec");
    end

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      start_op(ra, rb, model(ra, rb));
      wait_valid("rand");
      consume("rand");
    end

    // Backpressure: result must hold while a competing request is presented.
    bus.out_ready = 1'b0;
    e.diff = 8'd145; e.carry = 1'b1; e.ovf = 1'b0;
    start_op(8'd200, 8'd55, e);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 8'h11;
      bus.b        = 8'h22;
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_diff", {24'd0, bus.diff}, 32'd145);
      check("stall_carry", {31'd0, bus.carry_out}, 32'd1);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    consume("stall");
    check("stall_busy_after", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset while RUN is mid-way.
    start_op(8'h12, 8'h34, model(8'h12, 8'h34));
    @(posedge clk); #2;
    check("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_diff", {24'd0, bus.diff}, 32'd0);
    check("midrst_carry", {31'd0, bus.carry_out}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    e.diff = 8'd5; e.carry = 1'b1; e.ovf = 1'b0;
    start_op(8'd9, 8'd4, e);
    wait_valid("post_rst");
    consume("post_rst");

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
